// File: rtl/tdc_ctrl_pkg.sv
// Shared types and width helpers for the TDC measurement controller.
package tdc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    CAPTURE,
    WAIT_VAL,
    GAP,
    DONE
  } tdc_ctrl_state_e;

  localparam int HW_W_DEF   = 7;
  localparam int SAMP_W_DEF = 8;
  localparam int DLY_W_DEF  = 4;

  // Wide enough for (2**samp_w - 1) samples of (2**hw_w - 1) each.
  function automatic int tdc_sum_w(input int hw_w, input int samp_w);
    return hw_w + samp_w;
  endfunction

  function automatic int tdc_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tdc_acc.sv
// Burst accumulator: sum, sample count and, with TDC_MINMAX_EN defined, min/max tracking.
module tdc_acc
  import tdc_ctrl_pkg::*;
#(
  parameter int HW_W   = HW_W_DEF,
  parameter int SAMP_W = SAMP_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_clear,
  input  logic                                 i_add,
  input  logic [HW_W-1:0]                      i_hw,
  output logic [tdc_sum_w(HW_W, SAMP_W)-1:0]   o_sum,
  output logic [SAMP_W:0]                      o_cnt,
  output logic [HW_W-1:0]                      o_min,
  output logic [HW_W-1:0]                      o_max
);

  localparam int SUM_W = tdc_sum_w(HW_W, SAMP_W);
  localparam logic [SAMP_W:0] CNT_ONE = (SAMP_W+1)'(1);

  logic [SUM_W-1:0] r_sum;
  logic [SAMP_W:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + SUM_W'(i_hw);
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_sum = r_sum;
  assign o_cnt = r_cnt;

`ifdef TDC_MINMAX_EN
  logic [HW_W-1:0] r_min;
  logic [HW_W-1:0] r_max;

  // Clear to the neutral extremes so a zero-sample burst reports min=all-ones, max=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '0;
      r_max <= '0;
    end else if (i_clear) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_add) begin
      if (i_hw < r_min) r_min <= i_hw;
      if (i_hw > r_max) r_max <= i_hw;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;
`else
  assign o_min = '0;
  assign o_max = '0;
`endif

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Sequencer for one TDC measurement burst: launch/capture timing, result wait with timeout,
// accumulation and valid/ready result port. Optional min/max tracking via TDC_MINMAX_EN.
module tdc_meas_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int HW_W        = HW_W_DEF,
  parameter int SAMP_W      = SAMP_W_DEF,
  parameter int DLY_W       = DLY_W_DEF,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SAMP_W-1:0]             cfg_n_samp,
  input  logic [DLY_W-1:0]              cfg_cap_dly,
  output logic                          tdc_launch,
  output logic                          tdc_capture,
  output logic                          tdc_val_in,
  input  logic [HW_W-1:0]               tdc_hw,
  input  logic                          tdc_val_out,
  output logic                          busy,
  output logic [HW_W+SAMP_W-1:0]        res_sum,
  output logic [SAMP_W:0]               res_cnt,
  output logic                          res_err,
  output logic [HW_W-1:0]               res_min,
  output logic [HW_W-1:0]               res_max,
  output logic                          res_valid,
  input  logic                          res_ready
);

  localparam int TMR_W = $clog2(tdc_max3(2**DLY_W, GAP_CYC, TIMEOUT_CYC) + 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [SAMP_W:0]  CNT_ONE  = (SAMP_W+1)'(1);

  tdc_ctrl_state_e r_state;
  tdc_ctrl_state_e w_next;

  logic [TMR_W-1:0]  r_tmr;
  logic [SAMP_W-1:0] r_n_samp;
  logic [DLY_W-1:0]  r_cap_dly;
  logic              r_launch, r_capture, r_val_in, r_busy, r_valid, r_err;
  logic              w_launch_d, w_capture_d, w_val_in_d, w_busy_d, w_valid_d;
  logic              w_start_acc, w_sample, w_timeout, w_last, w_dly_end, w_gap_end;
  logic [SAMP_W:0]   w_cnt;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_sample    = (r_state == WAIT_VAL) && tdc_val_out;
  assign w_timeout   = (r_state == WAIT_VAL) && !tdc_val_out && (r_tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign w_last      = ((w_cnt + CNT_ONE) == {1'b0, r_n_samp});
  assign w_dly_end   = (r_tmr == TMR_W'(r_cap_dly - 1'b1));
  assign w_gap_end   = (r_tmr == TMR_W'(GAP_CYC - 1));

  // TDC pin and handshake outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_launch  <= 1'b0;
      r_capture <= 1'b0;
      r_val_in  <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_launch  <= w_launch_d;
      r_capture <= w_capture_d;
      r_val_in  <= w_val_in_d;
      r_busy    <= w_busy_d;
      r_valid   <= w_valid_d;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (start) w_next = LAUNCH;
      LAUNCH:   if (w_dly_end) w_next = CAPTURE;
      CAPTURE:  w_next = WAIT_VAL;
      // A sample arriving on the last timeout cycle still counts.
      WAIT_VAL: begin
        if (tdc_val_out) begin
          if (w_last)           w_next = DONE;
          else if (GAP_CYC > 0) w_next = GAP;
          else                  w_next = LAUNCH;
        end else if (w_timeout) begin
          w_next = DONE;
        end
      end
      GAP:      if (w_gap_end) w_next = LAUNCH;
      DONE:     if (res_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    w_launch_d  = (w_next == LAUNCH) || (w_next == CAPTURE);
    w_capture_d = (w_next == CAPTURE);
    w_val_in_d  = (w_next == LAUNCH);
    w_busy_d    = (w_next != IDLE);
    w_valid_d   = (w_next == DONE);
  end

  // One shared timer restarts on every state change and serves delay, gap and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if ((w_next != r_state) || (r_state == IDLE) || (r_state == DONE)) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + TMR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_samp  <= '0;
      r_cap_dly <= '0;
      r_err     <= 1'b0;
    end else if (w_start_acc) begin
      r_n_samp  <= (cfg_n_samp == '0) ? SAMP_W'(1) : cfg_n_samp;
      r_cap_dly <= (cfg_cap_dly == '0) ? DLY_W'(1) : cfg_cap_dly;
      r_err     <= 1'b0;
    end else if (w_timeout) begin
      r_err     <= 1'b1;
    end
  end

  tdc_acc #(
    .HW_W   (HW_W),
    .SAMP_W (SAMP_W)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start_acc),
    .i_add   (w_sample),
    .i_hw    (tdc_hw),
    .o_sum   (res_sum),
    .o_cnt   (w_cnt),
    .o_min   (res_min),
    .o_max   (res_max)
  );

  assign res_cnt     = w_cnt;
  assign tdc_launch  = r_launch;
  assign tdc_capture = r_capture;
  assign tdc_val_in  = r_val_in;
  assign busy        = r_busy;
  assign res_valid   = r_valid;
  assign res_err     = r_err;

endmodule
